uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte bundle for uart_rx
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_vld;
  logic       check_err;
  logic       frame_err;
  logic       busy;

  // Line/user side: drives the pin, consumes received bytes
  modport master (
    output rx,
    input  rx_data, rx_data_vld, check_err, frame_err, busy
  );

  // Receiver side
  modport slave (
    input  rx,
    output rx_data, rx_data_vld, check_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver (1 start, 8 data LSB first, optional parity, 1 stop); macro UART_RX_MAJORITY_EN enables 2-of-3 sampling
module uart_rx #(
  parameter logic [25:0] CLOCK     = 26'd50_000_000,
  parameter int          BAUD      = 9600,
  parameter string       CHECK_BIT = "None"
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int          BIT_CYC  = int'(CLOCK) / BAUD;
  localparam int          HALF     = BIT_CYC / 2;
  localparam logic [19:0] CYC_LAST = 20'(BIT_CYC - 1);
  localparam bit          PAR_EN   = (CHECK_BIT == "Odd") || (CHECK_BIT == "Even");
  localparam bit          PAR_ODD  = (CHECK_BIT == "Odd");

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    CHECK = 5'b01000,
    STOP  = 5'b10000
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_baud_q, cnt_baud_d;
  logic [2:0]  cnt_bit_q, cnt_bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        vld_q, vld_d;
  logic        cerr_q, cerr_d;
  logic        ferr_q, ferr_d;

  logic rx_meta_q, rx_s_q, rx_d_q;
  logic fall, bit_end, dec_pt, dec_bit, par_err;

  // Two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign fall    = rx_d_q & ~rx_s_q;
  assign bit_end = (cnt_baud_q == CYC_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic maj_a_q, maj_b_q;

  // Hold the two early votes; the third is the live sample at the decision point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maj_a_q <= 1'b1;
      maj_b_q <= 1'b1;
    end else begin
      if (cnt_baud_q == 20'(HALF - 2)) maj_a_q <= rx_s_q;
      if (cnt_baud_q == 20'(HALF - 1)) maj_b_q <= rx_s_q;
    end
  end

  assign dec_pt  = (cnt_baud_q == 20'(HALF));
  assign dec_bit = (maj_a_q & maj_b_q) | (maj_a_q & rx_s_q) | (maj_b_q & rx_s_q);
`else
  assign dec_pt  = (cnt_baud_q == 20'(HALF - 1));
  assign dec_bit = rx_s_q;
`endif

  // Odd: total ones must be odd; Even: total ones must be even
  assign par_err = PAR_EN ? (PAR_ODD ? ~^{shift_q, par_q} : ^{shift_q, par_q}) : 1'b0;

  // Next-state, counters, data path and output updates
  always_comb begin
    state_d    = state_q;
    cnt_baud_d = cnt_baud_q;
    cnt_bit_d  = cnt_bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    rx_data_d  = rx_data_q;
    vld_d      = 1'b0;
    cerr_d     = cerr_q;
    ferr_d     = ferr_q;

    if (state_q != IDLE) begin
      cnt_baud_d = bit_end ? 20'd0 : cnt_baud_q + 20'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          cnt_baud_d = 20'd0;
        end
      end
      START: begin
        // Line back high at mid start bit: treat as a glitch
        if (dec_pt && dec_bit) begin
          state_d    = IDLE;
          cnt_baud_d = 20'd0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (dec_pt) shift_d[cnt_bit_q] = dec_bit;
        if (bit_end) begin
          cnt_bit_d = cnt_bit_q + 3'd1;
          if (cnt_bit_q == 3'd7) state_d = PAR_EN ? CHECK : STOP;
        end
      end
      CHECK: begin
        if (dec_pt)  par_d   = dec_bit;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Finish at mid stop bit so a back-to-back start edge is not missed
        if (dec_pt) begin
          state_d    = IDLE;
          cnt_baud_d = 20'd0;
          rx_data_d  = shift_q;
          vld_d      = 1'b1;
          ferr_d     = ~dec_bit;
          cerr_d     = par_err;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_baud_d = 20'd0;
        cnt_bit_d  = 3'd0;
      end
    endcase
  end

  // State and data-path registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_baud_q <= 20'd0;
      cnt_bit_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      rx_data_q  <= 8'd0;
      vld_q      <= 1'b0;
      cerr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_baud_q <= cnt_baud_d;
      cnt_bit_q  <= cnt_bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      rx_data_q  <= rx_data_d;
      vld_q      <= vld_d;
      cerr_q     <= cerr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_data_vld = vld_q;
  assign bus.check_err   = cerr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx in None/Odd/Even parity modes
module tb_uart_rx;

  localparam int BC = 10;

  logic clk;
  logic rst_n;
  logic line;
  int   cyc;

  uart_rx_if if_none ();
  uart_rx_if if_odd ();
  uart_rx_if if_even ();

  assign if_none.rx = line;
  assign if_odd.rx  = line;
  assign if_even.rx = line;

  uart_rx #(.CLOCK(26'd1_000_000), .BAUD(100_000), .CHECK_BIT("None"))
    u_none (.clk(clk), .rst(rst_n), .bus(if_none));
  uart_rx #(.CLOCK(26'd1_000_000), .BAUD(100_000), .CHECK_BIT("Odd"))
    u_odd  (.clk(clk), .rst(rst_n), .bus(if_odd));
  uart_rx #(.CLOCK(26'd1_000_000), .BAUD(100_000), .CHECK_BIT("Even"))
    u_even (.clk(clk), .rst(rst_n), .bus(if_even));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       f;
    int         t;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  rec_t q2[$];
  logic vld_prev0;
  logic busy_after0;

  always @(negedge clk) begin
    if (if_none.rx_data_vld === 1'b1)
      q0.push_back('{if_none.rx_data, if_none.check_err, if_none.frame_err, cyc});
    if (if_odd.rx_data_vld === 1'b1)
      q1.push_back('{if_odd.rx_data, if_odd.check_err, if_odd.frame_err, cyc});
    if (if_even.rx_data_vld === 1'b1)
      q2.push_back('{if_even.rx_data, if_even.check_err, if_even.frame_err, cyc});
    if (vld_prev0 === 1'b1) busy_after0 <= if_none.busy;
    vld_prev0 <= if_none.rx_data_vld;
  end

  int n_vec;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bit_out(input logic b, input int n);
    line = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit hp, input bit p, input bit s, output int t0);
    t0 = cyc;
    bit_out(1'b0, BC);
    for (int i = 0; i < 8; i++) bit_out(d[i], BC);
    if (hp) bit_out(p, BC);
    bit_out(s, BC);
    line = 1'b1;
  endtask

  function automatic logic model_cerr(input int mode, input logic [7:0] d, input bit p);
    int ones;
    ones = $countones(d) + int'(p);
    if (mode == 1) return (ones % 2) == 0;
    if (mode == 2) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  task automatic clear_q();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic expect_one(input string nm, input int mode, input int t0,
                            input logic [7:0] d, input logic c, input logic f);
    rec_t r;
    int   n;
    int   lat;
    int   exp_lat;
    n = 0;
    case (mode)
      1:       begin n = q1.size(); if (n > 0) r = q1[0]; end
      2:       begin n = q2.size(); if (n > 0) r = q2[0]; end
      default: begin n = q0.size(); if (n > 0) r = q0[0]; end
    endcase
    chk({nm, " strobe count"}, n, 1);
    if (n > 0) begin
      chk({nm, " rx_data"}, r.d, d);
      chk({nm, " check_err"}, r.c, c);
      chk({nm, " frame_err"}, r.f, f);
      lat     = r.t - t0;
      exp_lat = 3 + BC * (9 + ((mode != 0) ? 1 : 0)) + BC / 2;
      n_vec++;
      if (lat < exp_lat - 1 || lat > exp_lat + 2) begin
        n_bad++;
        $display("FAIL %s latency: got %0d, expected %0d", nm, lat, exp_lat);
      end
    end
    clear_q();
  endtask

  typedef struct {
    logic [7:0] d;
    int         mode;
    bit         p;
    bit         s;
    logic [7:0] ed;
    logic       ec;
    logic       ef;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int t0;
    int t1;
    logic [7:0] rd;
    int mode;
    bit p;
    bit s;

    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    line  = 1'b1;
    rst_n = 1'b0;

    tbl[0] = '{8'hA5, 0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 2, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[4] = '{8'h3C, 0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[5] = '{8'h55, 0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[6] = '{8'hE0, 2, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0};
    tbl[7] = '{8'h81, 1, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_data", if_none.rx_data, 8'h00);
    chk("reset rx_data_vld", if_none.rx_data_vld, 1'b0);
    chk("reset check_err", if_odd.check_err, 1'b0);
    chk("reset frame_err", if_none.frame_err, 1'b0);
    chk("reset busy", if_none.busy, 1'b0);
    rst_n = 1'b1;
    bit_out(1'b1, 20);
    clear_q();

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].d, tbl[i].mode != 0, tbl[i].p, tbl[i].s, t0);
      bit_out(1'b1, 120);
      expect_one($sformatf("vec%0d", i), tbl[i].mode, t0, tbl[i].ed, tbl[i].ec, tbl[i].ef);
      if (i == 0) chk("busy after strobe", busy_after0, 1'b0);
    end

    // Short low glitch on an idle line must not produce a frame
    bit_out(1'b0, 3);
    bit_out(1'b1, 200);
    chk("glitch strobe count", q0.size(), 0);
    chk("glitch busy", if_none.busy, 1'b0);
    clear_q();
    send(8'h81, 1'b0, 1'b0, 1'b1, t0);
    bit_out(1'b1, 120);
    expect_one("after glitch", 0, t0, 8'h81, 1'b0, 1'b0);

    // Back-to-back frames with no idle gap
    send(8'h00, 1'b0, 1'b0, 1'b1, t0);
    send(8'hFF, 1'b0, 1'b0, 1'b1, t1);
    bit_out(1'b1, 120);
    chk("b2b strobe count", q0.size(), 2);
    if (q0.size() == 2) begin
      chk("b2b first data", q0[0].d, 8'h00);
      chk("b2b second data", q0[1].d, 8'hFF);
      chk("b2b spacing", q0[1].t - q0[0].t, 100);
      chk("b2b second frame_err", q0[1].f, 1'b0);
    end
    clear_q();

    // Reset during bit 4 of a frame discards it
    rd = 8'h96;
    bit_out(1'b0, BC);
    for (int i = 0; i < 4; i++) bit_out(rd[i], BC);
    bit_out(rd[4], 5);
    chk("mid-frame busy", if_none.busy, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid-reset rx_data", if_none.rx_data, 8'h00);
    chk("mid-reset busy", if_none.busy, 1'b0);
    chk("mid-reset vld", if_none.rx_data_vld, 1'b0);
    line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bit_out(1'b1, 200);
    chk("post-reset strobe count", q0.size(), 0);
    chk("post-reset rx_data", if_none.rx_data, 8'h00);
    chk("post-reset frame_err", if_none.frame_err, 1'b0);
    clear_q();

    // Break: line held low well past a frame
    t0 = cyc;
    bit_out(1'b0, 150);
    bit_out(1'b1, 120);
    expect_one("break", 0, t0, 8'h00, 1'b0, 1'b1);

    // Randomized frames against the reference model
    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 2));
      rd   = 8'($urandom);
      p    = 1'($urandom_range(0, 1));
      s    = ($urandom_range(0, 3) != 0);
      send(rd, mode != 0, p, s, t0);
      bit_out(1'b1, 120);
      expect_one($sformatf("rand%0d", i), mode, t0, rd, model_cerr(mode, rd, p), ~s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
